maze_solver: RTL and testbench

- Command-issuing end of the navigation handshake: a wall-following maze solver that drives `strt_hdng`, `strt_mv`, `stp_lft`, `stp_rght` and `dsrd_hdng` into the navigation block.
- It waits on `mv_cmplt` for each command and uses the IR opening flags to pick the next heading.
- It sits between the command/UART front end (which supplies `go` and the affinity) and navigation plus the heading PID.
- It runs until `sol_cmplt` (magnet found) or a watchdog timeout.

---
 rtl/maze_solver.sv | 179 +++++++++++++++++
 tb/tb_maze_solver.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_solver.sv
// Wall-following maze solver: issues heading/move commands to navigation, waits on
// mv_cmplt for each one, and picks the next heading from the IR opening flags.
module maze_solver #(
  parameter logic [25:0] TMO_CYC = 26'd50_000_000,
  parameter logic [11:0] HDNG_N  = 12'h000,
  parameter logic [11:0] HDNG_W  = 12'h3FF,
  parameter logic [11:0] HDNG_S  = 12'h7FF,
  parameter logic [11:0] HDNG_E  = 12'hC00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        cmd_md,
  input  logic        sol_cmplt,
  input  logic        mv_cmplt,
  input  logic        lft_opn,
  input  logic        rght_opn,
  input  logic        frwrd_opn,
  output logic        strt_hdng,
  output logic        strt_mv,
  output logic        stp_lft,
  output logic        stp_rght,
  output logic [11:0] dsrd_hdng,
  output logic [7:0]  mv_cnt,
  output logic        done,
  output logic        err
);

  localparam int unsigned WD_W  = 26;
  localparam int unsigned DIR_W = 2;

  typedef enum logic [2:0] {
    IDLE, MOVE, WAIT_MV, DECIDE, HDNG, WAIT_HDNG, DONE, ERR
  } state_e;

  // Direction encoding makes a left turn +1, a right turn -1 and a U-turn +2.
  localparam logic [DIR_W-1:0] DIR_N = 2'd0;
  localparam logic [DIR_W-1:0] DIR_W_ = 2'd1;
  localparam logic [DIR_W-1:0] DIR_S = 2'd2;
  localparam logic [DIR_W-1:0] DIR_E = 2'd3;

  state_e           state_q, state_d;
  logic             aff_q, aff_d;
  logic [DIR_W-1:0] dir_q, dir_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [7:0]       mv_cnt_q, mv_cnt_d;
  logic [11:0]      dsrd_hdng_q, dsrd_hdng_d;
  logic             strt_hdng_q, strt_hdng_d;
  logic             strt_mv_q, strt_mv_d;
  logic             stp_lft_q, stp_lft_d;
  logic             stp_rght_q, stp_rght_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             in_wait_c;
  logic             expired_c;
  logic             turn_c;
  logic [DIR_W-1:0] turn_dir_c;

  assign in_wait_c = (state_q == WAIT_MV) || (state_q == WAIT_HDNG);
  assign expired_c = in_wait_c && (wd_q == TMO_CYC - 26'd1);

  // Turn selection by affinity priority; straight leaves turn_c low.
  always_comb begin
    turn_c     = 1'b1;
    turn_dir_c = dir_q + 2'd2;
    if (aff_q) begin
      if (lft_opn)        turn_dir_c = dir_q + 2'd1;
      else if (frwrd_opn) turn_c = 1'b0;
      else if (rght_opn)  turn_dir_c = dir_q - 2'd1;
    end else begin
      if (rght_opn)       turn_dir_c = dir_q - 2'd1;
      else if (frwrd_opn) turn_c = 1'b0;
      else if (lft_opn)   turn_dir_c = dir_q + 2'd1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; sol_cmplt outranks every other event once a solve is running.
  always_comb begin
    state_d = state_q;
    if (state_q != IDLE && state_q != ERR && sol_cmplt) begin
      state_d = DONE;
    end else begin
      unique case (state_q)
        IDLE:      if (go) state_d = MOVE;
        MOVE:      state_d = WAIT_MV;
        WAIT_MV:   if (mv_cmplt) state_d = DECIDE;
                   else if (expired_c) state_d = ERR;
        DECIDE:    state_d = turn_c ? HDNG : MOVE;
        HDNG:      state_d = WAIT_HDNG;
        WAIT_HDNG: if (mv_cmplt) state_d = MOVE;
                   else if (expired_c) state_d = ERR;
        DONE:      state_d = DONE;
        ERR:       state_d = ERR;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Output and datapath next values, all derived from the upcoming state.
  always_comb begin
    aff_d    = aff_q;
    dir_d    = dir_q;
    mv_cnt_d = mv_cnt_q;
    wd_d     = in_wait_c ? wd_q + 26'd1 : '0;
    if (state_q == IDLE && go) begin
      aff_d    = cmd_md;
      mv_cnt_d = '0;
    end
    if (state_q == WAIT_MV && state_d == DECIDE && mv_cnt_q != 8'hFF) begin
      mv_cnt_d = mv_cnt_q + 8'd1;
    end
    if (state_d == HDNG) dir_d = turn_dir_c;

    unique case (dir_d)
      DIR_N:   dsrd_hdng_d = HDNG_N;
      DIR_W_:  dsrd_hdng_d = HDNG_W;
      DIR_S:   dsrd_hdng_d = HDNG_S;
      DIR_E:   dsrd_hdng_d = HDNG_E;
      default: dsrd_hdng_d = HDNG_N;
    endcase

    strt_mv_d   = (state_d == MOVE);
    strt_hdng_d = (state_d == HDNG);
    done_d      = (state_d == DONE);
    err_d       = (state_d == ERR);
    stp_lft_d   = 1'b0;
    stp_rght_d  = 1'b0;
    if (state_d != IDLE && state_d != DONE && state_d != ERR) begin
      stp_lft_d  = aff_d;
      stp_rght_d = ~aff_d;
    end
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aff_q       <= 1'b0;
      dir_q       <= DIR_N;
      wd_q        <= '0;
      mv_cnt_q    <= '0;
      dsrd_hdng_q <= HDNG_N;
      strt_hdng_q <= 1'b0;
      strt_mv_q   <= 1'b0;
      stp_lft_q   <= 1'b0;
      stp_rght_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      aff_q       <= aff_d;
      dir_q       <= dir_d;
      wd_q        <= wd_d;
      mv_cnt_q    <= mv_cnt_d;
      dsrd_hdng_q <= dsrd_hdng_d;
      strt_hdng_q <= strt_hdng_d;
      strt_mv_q   <= strt_mv_d;
      stp_lft_q   <= stp_lft_d;
      stp_rght_q  <= stp_rght_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign strt_hdng = strt_hdng_q;
  assign strt_mv   = strt_mv_q;
  assign stp_lft   = stp_lft_q;
  assign stp_rght  = stp_rght_q;
  assign dsrd_hdng = dsrd_hdng_q;
  assign mv_cnt    = mv_cnt_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_maze_solver.sv
// Directed bench for maze_solver: turn selection, move counting, watchdog,
// solve completion and reset behaviour, with hand-computed expectations.
module tb_maze_solver;

  logic        clk = 1'b0;
  logic        rst, go, cmd_md, sol_cmplt, mv_cmplt, lft_opn, rght_opn, frwrd_opn;
  logic        strt_hdng, strt_mv, stp_lft, stp_rght, done, err;
  logic [11:0] dsrd_hdng;
  logic [7:0]  mv_cnt;

  int checks = 0;
  int errors = 0;

  maze_solver #(.TMO_CYC(26'd100)) dut (
    .clk(clk), .rst(rst), .go(go), .cmd_md(cmd_md), .sol_cmplt(sol_cmplt),
    .mv_cmplt(mv_cmplt), .lft_opn(lft_opn), .rght_opn(rght_opn), .frwrd_opn(frwrd_opn),
    .strt_hdng(strt_hdng), .strt_mv(strt_mv), .stp_lft(stp_lft), .stp_rght(stp_rght),
    .dsrd_hdng(dsrd_hdng), .mv_cnt(mv_cnt), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; go = 1'b0; cmd_md = 1'b0; sol_cmplt = 1'b0; mv_cmplt = 1'b0;
    lft_opn = 1'b0; rght_opn = 1'b0; frwrd_opn = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic start_solve(input logic md);
    cmd_md = md;
    go = 1'b1;
    step();
    go = 1'b0;
  endtask

  task automatic pulse_mv(input logic l, input logic f, input logic r);
    lft_opn = l; frwrd_opn = f; rght_opn = r;
    mv_cmplt = 1'b1;
    step();
    mv_cmplt = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] outs;
    rst = 1'b1; go = 1'b0; cmd_md = 1'b0; sol_cmplt = 1'b0; mv_cmplt = 1'b0;
    lft_opn = 1'b0; rght_opn = 1'b0; frwrd_opn = 1'b0;
    step();
    outs = {strt_hdng, strt_mv, stp_lft, stp_rght, done, err, mv_cnt, dsrd_hdng[9:0]};
    checks++;
    if (outs !== 24'h0) begin
      errors++; $display("FAIL reset_outputs got %h exp 000000", outs);
    end
    checks++;
    if (dsrd_hdng !== 12'h000) begin
      errors++; $display("FAIL reset_hdng got %h exp 000", dsrd_hdng);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({strt_hdng, strt_mv, stp_lft, stp_rght} !== 4'b0) begin
      errors++; $display("FAIL post_reset_idle got %b exp 0000", {strt_hdng, strt_mv, stp_lft, stp_rght});
    end
  endtask

  task automatic test_start();
    apply_reset();
    start_solve(1'b1);
    checks++;
    if ({strt_mv, strt_hdng, stp_lft, stp_rght} !== 4'b1010) begin
      errors++; $display("FAIL start_pulse got %b exp 1010", {strt_mv, strt_hdng, stp_lft, stp_rght});
    end
    checks++;
    if (dsrd_hdng !== 12'h000) begin
      errors++; $display("FAIL start_hdng got %h exp 000", dsrd_hdng);
    end
    step();
    checks++;
    if (strt_mv !== 1'b0) begin
      errors++; $display("FAIL start_one_cycle got %b exp 0", strt_mv);
    end
    go = 1'b1;
    step();
    go = 1'b0;
    step();
    checks++;
    if ({strt_mv, strt_hdng, mv_cnt} !== 10'h0) begin
      errors++; $display("FAIL go_ignored got %h exp 000", {strt_mv, strt_hdng, mv_cnt});
    end
  endtask

  // Continues from test_start: in WAIT_MV, left affinity, heading N.
  task automatic test_left_turn();
    pulse_mv(1'b1, 1'b1, 1'b0);
    checks++;
    if ({strt_hdng, strt_mv, mv_cnt} !== 10'h001) begin
      errors++; $display("FAIL decide_cycle got %h exp 001", {strt_hdng, strt_mv, mv_cnt});
    end
    step();
    checks++;
    if ({strt_hdng, strt_mv} !== 2'b10 || dsrd_hdng !== 12'h3FF) begin
      errors++; $display("FAIL left_turn got %b/%h exp 10/3ff", {strt_hdng, strt_mv}, dsrd_hdng);
    end
    step();
    checks++;
    if (strt_hdng !== 1'b0) begin
      errors++; $display("FAIL hdng_one_cycle got %b exp 0", strt_hdng);
    end
    pulse_mv(1'b0, 1'b0, 1'b0);
    checks++;
    if ({strt_mv, strt_hdng} !== 2'b10 || mv_cnt !== 8'd1 || dsrd_hdng !== 12'h3FF) begin
      errors++; $display("FAIL move_after_hdng got %b/%h/%h exp 10/01/3ff", {strt_mv, strt_hdng}, mv_cnt, dsrd_hdng);
    end
  endtask

  task automatic test_right_uturn();
    apply_reset();
    start_solve(1'b0);
    checks++;
    if ({stp_lft, stp_rght} !== 2'b01) begin
      errors++; $display("FAIL right_stp got %b exp 01", {stp_lft, stp_rght});
    end
    step();
    pulse_mv(1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (strt_hdng !== 1'b1 || dsrd_hdng !== 12'h7FF) begin
      errors++; $display("FAIL uturn_n_to_s got %b/%h exp 1/7ff", strt_hdng, dsrd_hdng);
    end
    step(); pulse_mv(1'b0, 1'b0, 1'b0); step();
    pulse_mv(1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if (strt_hdng !== 1'b1 || dsrd_hdng !== 12'hC00) begin
      errors++; $display("FAIL left_s_to_e got %b/%h exp 1/c00", strt_hdng, dsrd_hdng);
    end
    step(); pulse_mv(1'b0, 1'b0, 1'b0); step();
    pulse_mv(1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (strt_hdng !== 1'b1 || dsrd_hdng !== 12'h3FF) begin
      errors++; $display("FAIL uturn_e_to_w got %b/%h exp 1/3ff", strt_hdng, dsrd_hdng);
    end
    step(); pulse_mv(1'b0, 1'b0, 1'b0); step();
    pulse_mv(1'b1, 1'b1, 1'b1);
    step();
    checks++;
    if (strt_hdng !== 1'b1 || dsrd_hdng !== 12'h000) begin
      errors++; $display("FAIL right_prio_w_to_n got %b/%h exp 1/000", strt_hdng, dsrd_hdng);
    end
  endtask

  task automatic test_straight_sat();
    apply_reset();
    start_solve(1'b1);
    step();
    for (int i = 0; i < 300; i++) begin
      pulse_mv(1'b0, 1'b1, 1'b1);
      checks++;
      if ({strt_mv, strt_hdng} !== 2'b00) begin
        errors++; $display("FAIL straight_decide[%0d] got %b exp 00", i, {strt_mv, strt_hdng});
      end
      step();
      checks++;
      if ({strt_mv, strt_hdng} !== 2'b10) begin
        errors++; $display("FAIL straight_move[%0d] got %b exp 10", i, {strt_mv, strt_hdng});
      end
      if (i == 199) begin
        checks++;
        if (mv_cnt !== 8'd200) begin
          errors++; $display("FAIL mv_cnt_200 got %0d exp 200", mv_cnt);
        end
      end
      step();
    end
    checks++;
    if (mv_cnt !== 8'hFF || dsrd_hdng !== 12'h000) begin
      errors++; $display("FAIL mv_cnt_sat got %h/%h exp ff/000", mv_cnt, dsrd_hdng);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    start_solve(1'b1);
    step();
    repeat (99) step();
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL tmo_early got %b exp 0", err);
    end
    step();
    checks++;
    if ({err, done, strt_mv, strt_hdng, stp_lft, stp_rght} !== 6'b100000) begin
      errors++; $display("FAIL tmo_err got %b exp 100000", {err, done, strt_mv, strt_hdng, stp_lft, stp_rght});
    end
    go = 1'b1; mv_cmplt = 1'b1;
    step();
    go = 1'b0; mv_cmplt = 1'b0;
    step();
    checks++;
    if ({err, strt_mv, strt_hdng} !== 3'b100 || mv_cnt !== 8'd0) begin
      errors++; $display("FAIL err_sticky got %b/%h exp 100/00", {err, strt_mv, strt_hdng}, mv_cnt);
    end
  endtask

  task automatic test_timeout_rescue();
    apply_reset();
    start_solve(1'b1);
    step();
    repeat (99) step();
    pulse_mv(1'b0, 1'b1, 1'b0);
    checks++;
    if (err !== 1'b0 || mv_cnt !== 8'd1) begin
      errors++; $display("FAIL tmo_rescue got %b/%h exp 0/01", err, mv_cnt);
    end
    step();
    checks++;
    if (strt_mv !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL tmo_rescue_mv got %b/%b exp 1/0", strt_mv, err);
    end
    step();
    pulse_mv(1'b1, 1'b0, 1'b0);
    step();
    step();
    repeat (99) step();
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL tmo_hdng_early got %b exp 0", err);
    end
    step();
    checks++;
    if (err !== 1'b1 || strt_mv !== 1'b0) begin
      errors++; $display("FAIL tmo_hdng_err got %b/%b exp 1/0", err, strt_mv);
    end
  endtask

  task automatic test_sol();
    apply_reset();
    start_solve(1'b1);
    step();
    sol_cmplt = 1'b1;
    pulse_mv(1'b0, 1'b1, 1'b0);
    sol_cmplt = 1'b0;
    checks++;
    if ({done, err, strt_mv, strt_hdng, stp_lft, stp_rght} !== 6'b100000 || mv_cnt !== 8'd0) begin
      errors++; $display("FAIL sol_wait_mv got %b/%h exp 100000/00", {done, err, strt_mv, strt_hdng, stp_lft, stp_rght}, mv_cnt);
    end
    step();
    checks++;
    if ({done, strt_mv, strt_hdng} !== 3'b100) begin
      errors++; $display("FAIL done_sticky got %b exp 100", {done, strt_mv, strt_hdng});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({done, err, strt_mv, strt_hdng, stp_lft, stp_rght, mv_cnt} !== 14'h0 || dsrd_hdng !== 12'h000) begin
      errors++; $display("FAIL rst_after_done got %h/%h exp 0000/000", {done, err, strt_mv, strt_hdng, stp_lft, stp_rght, mv_cnt}, dsrd_hdng);
    end
    step();
    rst = 1'b0;
    start_solve(1'b1);
    step();
    pulse_mv(1'b0, 1'b1, 1'b0);
    sol_cmplt = 1'b1;
    step();
    sol_cmplt = 1'b0;
    checks++;
    if ({done, strt_mv, strt_hdng} !== 3'b100 || mv_cnt !== 8'd1) begin
      errors++; $display("FAIL sol_decide got %b/%h exp 100/01", {done, strt_mv, strt_hdng}, mv_cnt);
    end
  endtask

  task automatic test_reset_midsolve();
    apply_reset();
    start_solve(1'b1);
    step();
    pulse_mv(1'b1, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    #1;
    checks++;
    if ({strt_hdng, stp_lft} !== 2'b00 || dsrd_hdng !== 12'h000) begin
      errors++; $display("FAIL rst_midsolve got %b/%h exp 00/000", {strt_hdng, stp_lft}, dsrd_hdng);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({strt_hdng, strt_mv, stp_lft, stp_rght} !== 4'b0) begin
      errors++; $display("FAIL rst_release_quiet got %b exp 0000", {strt_hdng, strt_mv, stp_lft, stp_rght});
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_left_turn();
    test_right_uturn();
    test_straight_sat();
    test_timeout();
    test_timeout_rescue();
    test_sol();
    test_reset_midsolve();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
